// File: rtl/glitch_sequencer.sv
// Glitch sequencer: arms on a latched configuration and fires a delayed burst of
// fixed-width pulses on a synchronised trigger edge, with abort and auto-rearm.
module glitch_sequencer #(
    parameter int CNT_W       = 32,
    parameter int REP_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ARM,
    input  logic             ABORT,
    input  logic             TRIG_IN,
    input  logic             AUTO_REARM,
    input  logic [CNT_W-1:0] CFG_DELAY,
    input  logic [CNT_W-1:0] CFG_WIDTH,
    input  logic [CNT_W-1:0] CFG_GAP,
    input  logic [REP_W-1:0] CFG_COUNT,
    output logic             GLITCH_OUT,
    output logic             STATE_ARMED,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic             IDLE_LEVEL = !ACTIVE_HIGH;
    localparam logic             ON_LEVEL   = ACTIVE_HIGH;
    localparam logic [CNT_W-1:0] CNT_ONE    = 1;
    localparam logic [REP_W-1:0] REP_ONE    = 1;

    logic [1:0]             rst_pipe;
    logic                   rst_int_n;
    logic [SYNC_STAGES-1:0] trig_sync;
    logic [SYNC_STAGES:0]   trig_valid;
    logic                   trig_prev;
    logic                   trig_edge;

    logic [2:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [REP_W-1:0] rem, rem_next;
    logic             done_q, done_next;
    logic             glitch_q;

    logic [CNT_W-1:0] delay_s, width_s, gap_s;
    logic [REP_W-1:0] count_s;
    logic             rearm_s;
    logic [CNT_W-1:0] width_m1, gap_m1;
    logic [REP_W-1:0] count_eff;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_int_n = rst_pipe[1];

    // trig_valid masks edges until trig_prev holds a genuinely sampled level,
    // so a trigger already high at reset release never looks like a rise.
    always_ff @(posedge CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            trig_sync  <= '0;
            trig_prev  <= 1'b0;
            trig_valid <= '0;
        end else begin
            trig_sync  <= {trig_sync[SYNC_STAGES-2:0], TRIG_IN};
            trig_prev  <= trig_sync[SYNC_STAGES-1];
            trig_valid <= {trig_valid[SYNC_STAGES-1:0], 1'b1};
        end
    end
    assign trig_edge = trig_valid[SYNC_STAGES] & trig_sync[SYNC_STAGES-1] & ~trig_prev;

    assign width_m1  = (width_s == '0) ? '0 : width_s - CNT_ONE;
    assign gap_m1    = (gap_s == '0) ? '0 : gap_s - CNT_ONE;
    assign count_eff = (count_s == '0) ? REP_ONE : count_s;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rem_next   = rem;
        done_next  = 1'b0;
        if (ABORT) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            rem_next   = '0;
        end else if (ARM) begin
            state_next = S_ARMED;
            cnt_next   = '0;
            rem_next   = (CFG_COUNT == '0) ? REP_ONE : CFG_COUNT;
        end else begin
            case (state)
                S_IDLE: ;
                S_ARMED: begin
                    if (trig_edge) begin
                        if (delay_s != '0) begin
                            state_next = S_DELAY;
                            cnt_next   = delay_s - CNT_ONE;
                        end else begin
                            state_next = S_PULSE;
                            cnt_next   = width_m1;
                        end
                    end
                end
                S_DELAY, S_GAP: begin
                    if (cnt == '0) begin
                        state_next = S_PULSE;
                        cnt_next   = width_m1;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
                S_PULSE: begin
                    if (cnt != '0) begin
                        cnt_next = cnt - CNT_ONE;
                    end else if (rem > REP_ONE) begin
                        rem_next   = rem - REP_ONE;
                        state_next = S_GAP;
                        cnt_next   = gap_m1;
                    end else begin
                        done_next = 1'b1;
                        cnt_next  = '0;
                        if (rearm_s) begin
                            state_next = S_ARMED;
                            rem_next   = count_eff;
                        end else begin
                            state_next = S_IDLE;
                            rem_next   = '0;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // The output level is decided from the next state so it lines up with PULSE.
    always_ff @(posedge CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem      <= '0;
            done_q   <= 1'b0;
            glitch_q <= IDLE_LEVEL;
            delay_s  <= '0;
            width_s  <= '0;
            gap_s    <= '0;
            count_s  <= '0;
            rearm_s  <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            rem      <= rem_next;
            done_q   <= done_next;
            glitch_q <= (state_next == S_PULSE) ? ON_LEVEL : IDLE_LEVEL;
            if (ARM && !ABORT) begin
                delay_s <= CFG_DELAY;
                width_s <= CFG_WIDTH;
                gap_s   <= CFG_GAP;
                count_s <= CFG_COUNT;
                rearm_s <= AUTO_REARM;
            end
        end
    end

    assign GLITCH_OUT  = glitch_q;
    assign DONE        = done_q;
    assign STATE_ARMED = (state == S_ARMED);
    assign BUSY        = (state == S_DELAY) || (state == S_PULSE) || (state == S_GAP);

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: a per-cycle expected waveform is queued
// as each burst is launched and compared against two instances (both polarities).
module tb_glitch_sequencer;

    localparam int CNT_W = 8;
    localparam int REP_W = 4;
    localparam int SYNC  = 2;

    logic             CLK = 1'b0;
    logic             RST_N, ARM, ABORT, TRIG_IN, AUTO_REARM;
    logic [CNT_W-1:0] CFG_DELAY, CFG_WIDTH, CFG_GAP;
    logic [REP_W-1:0] CFG_COUNT;
    logic             glitch, armed, busy, done;
    logic             glitch_n, armed_n, busy_n, done_n;

    typedef struct packed {
        logic glitch;
        logic done;
        logic busy;
        logic armed;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    glitch_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W), .SYNC_STAGES(SYNC), .ACTIVE_HIGH(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .ARM(ARM), .ABORT(ABORT), .TRIG_IN(TRIG_IN),
        .AUTO_REARM(AUTO_REARM), .CFG_DELAY(CFG_DELAY), .CFG_WIDTH(CFG_WIDTH),
        .CFG_GAP(CFG_GAP), .CFG_COUNT(CFG_COUNT), .GLITCH_OUT(glitch),
        .STATE_ARMED(armed), .BUSY(busy), .DONE(done)
    );

    glitch_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W), .SYNC_STAGES(SYNC), .ACTIVE_HIGH(1'b0)) dut_n (
        .CLK(CLK), .RST_N(RST_N), .ARM(ARM), .ABORT(ABORT), .TRIG_IN(TRIG_IN),
        .AUTO_REARM(AUTO_REARM), .CFG_DELAY(CFG_DELAY), .CFG_WIDTH(CFG_WIDTH),
        .CFG_GAP(CFG_GAP), .CFG_COUNT(CFG_COUNT), .GLITCH_OUT(glitch_n),
        .STATE_ARMED(armed_n), .BUSY(busy_n), .DONE(done_n)
    );

    task automatic checkBit(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pushSample(input logic g, input logic d, input logic b, input logic a);
        exp_t e;
        e.glitch = g;
        e.done   = d;
        e.busy   = b;
        e.armed  = a;
        exp_q.push_back(e);
    endtask

    task automatic pushIdle(input int n, input logic a);
        repeat (n) pushSample(1'b0, 1'b0, 1'b0, a);
    endtask

    // Expected waveform from the sample right after the trigger is raised.
    task automatic pushBurst(input int d, input int w, input int g, input int c, input logic rearm);
        int we, ge, ce;
        we = (w == 0) ? 1 : w;
        ge = (g == 0) ? 1 : g;
        ce = (c == 0) ? 1 : c;
        repeat (SYNC + 1) pushSample(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (d) pushSample(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < ce; i++) begin
            repeat (we) pushSample(1'b1, 1'b0, 1'b1, 1'b0);
            if (i < ce - 1) repeat (ge) pushSample(1'b0, 1'b0, 1'b1, 1'b0);
        end
        pushSample(1'b0, 1'b1, 1'b0, rearm);
        pushIdle(3, rearm);
    endtask

    task automatic applyStimulus(input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] w,
                                 input logic [CNT_W-1:0] g, input logic [REP_W-1:0] c,
                                 input logic rearm);
        @(posedge CLK);
        #1;
        CFG_DELAY  = d;
        CFG_WIDTH  = w;
        CFG_GAP    = g;
        CFG_COUNT  = c;
        AUTO_REARM = rearm;
        ARM        = 1'b1;
        @(posedge CLK);
        #1;
        ARM        = 1'b0;
        CFG_DELAY  = CNT_W'($urandom);
        CFG_WIDTH  = CNT_W'($urandom);
        CFG_GAP    = CNT_W'($urandom);
        CFG_COUNT  = REP_W'($urandom);
        AUTO_REARM = ~rearm;
    endtask

    // Drains the queue one sample per cycle; optionally wiggles TRIG_IN mid-run.
    task automatic checkOutput(input int toggleAt);
        exp_t e;
        int   idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            e = exp_q.pop_front();
            checkBit("glitch", glitch, e.glitch);
            checkBit("glitch_inv", glitch_n, ~e.glitch);
            checkBit("done", done, e.done);
            checkBit("done_inv", done_n, e.done);
            checkBit("busy", busy, e.busy);
            checkBit("busy_inv", busy_n, e.busy);
            checkBit("armed", armed, e.armed);
            checkBit("armed_inv", armed_n, e.armed);
            if (toggleAt >= 0) begin
                if (idx == toggleAt)     TRIG_IN = 1'b0;
                if (idx == toggleAt + 4) TRIG_IN = 1'b1;
                if (idx == toggleAt + 8) TRIG_IN = 1'b0;
            end
            idx++;
        end
    endtask

    initial begin
        RST_N = 1'b0; ARM = 1'b0; ABORT = 1'b0; TRIG_IN = 1'b0; AUTO_REARM = 1'b0;
        CFG_DELAY = '0; CFG_WIDTH = '0; CFG_GAP = '0; CFG_COUNT = '0;
        #12;
        checkBit("rst_glitch", glitch, 1'b0);
        checkBit("rst_glitch_inv", glitch_n, 1'b1);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_armed", armed, 1'b0);
        checkBit("rst_done", done, 1'b0);
        tick();
        RST_N = 1'b1;
        repeat (4) tick();
        pushIdle(4, 1'b0);
        checkOutput(-1);

        $display("[TB] single long pulse after delay");
        applyStimulus(8'd10, 8'd95, 8'd0, 4'd1, 1'b0);
        TRIG_IN = 1'b1;
        pushBurst(10, 95, 0, 1, 1'b0);
        checkOutput(-1);
        TRIG_IN = 1'b0;

        $display("[TB] trigger while idle is ignored");
        repeat (4) tick();
        TRIG_IN = 1'b1;
        pushIdle(10, 1'b0);
        checkOutput(-1);
        TRIG_IN = 1'b0;

        $display("[TB] zero delay, four pulses with gaps");
        applyStimulus(8'd0, 8'd3, 8'd5, 4'd4, 1'b0);
        TRIG_IN = 1'b1;
        pushBurst(0, 3, 5, 4, 1'b0);
        checkOutput(-1);
        TRIG_IN = 1'b0;

        $display("[TB] zero width and zero count");
        applyStimulus(8'd3, 8'd0, 8'd7, 4'd0, 1'b0);
        TRIG_IN = 1'b1;
        pushBurst(3, 0, 7, 0, 1'b0);
        checkOutput(-1);
        TRIG_IN = 1'b0;

        $display("[TB] all-ones delay and width");
        applyStimulus(8'd255, 8'd255, 8'd0, 4'd2, 1'b0);
        TRIG_IN = 1'b1;
        pushBurst(255, 255, 0, 2, 1'b0);
        checkOutput(-1);
        TRIG_IN = 1'b0;

        $display("[TB] auto rearm, three bursts, mid-burst trigger ignored");
        applyStimulus(8'd2, 8'd3, 8'd2, 4'd3, 1'b1);
        for (int b = 0; b < 3; b++) begin
            TRIG_IN = 1'b1;
            pushBurst(2, 3, 2, 3, 1'b1);
            checkOutput(4);
            pushIdle(170, 1'b1);
            checkOutput(-1);
            tick();
        end

        $display("[TB] abort during second pulse");
        applyStimulus(8'd1, 8'd4, 8'd2, 4'd3, 1'b0);
        TRIG_IN = 1'b1;
        pushIdle(SYNC + 1, 1'b1);
        repeat (1) pushSample(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) pushSample(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) pushSample(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) pushSample(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput(-1);
        ABORT = 1'b1;
        pushIdle(4, 1'b0);
        checkOutput(-1);
        ABORT = 1'b0;
        pushIdle(12, 1'b0);
        checkOutput(-1);
        TRIG_IN = 1'b0;

        $display("[TB] arm during pulse cancels and rearms");
        applyStimulus(8'd0, 8'd30, 8'd1, 4'd2, 1'b0);
        TRIG_IN = 1'b1;
        pushIdle(SYNC + 1, 1'b1);
        repeat (5) pushSample(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput(-1);
        applyStimulus(8'd2, 8'd2, 8'd2, 4'd1, 1'b1);
        pushIdle(6, 1'b1);
        checkOutput(-1);
        TRIG_IN = 1'b0;
        pushIdle(4, 1'b1);
        checkOutput(-1);
        tick();
        TRIG_IN = 1'b1;
        pushBurst(2, 2, 2, 1, 1'b1);
        checkOutput(-1);
        TRIG_IN = 1'b0;

        $display("[TB] reset mid-pulse with trigger held high");
        applyStimulus(8'd0, 8'd20, 8'd1, 4'd1, 1'b0);
        TRIG_IN = 1'b1;
        pushIdle(SYNC + 1, 1'b1);
        repeat (4) pushSample(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput(-1);
        RST_N = 1'b0;
        #1;
        checkBit("midrst_glitch", glitch, 1'b0);
        checkBit("midrst_glitch_inv", glitch_n, 1'b1);
        checkBit("midrst_busy", busy, 1'b0);
        checkBit("midrst_done", done, 1'b0);
        checkBit("midrst_armed", armed, 1'b0);
        tick();
        RST_N = 1'b1;
        tick();
        applyStimulus(8'd0, 8'd2, 8'd1, 4'd1, 1'b0);
        pushIdle(12, 1'b1);
        checkOutput(-1);
        TRIG_IN = 1'b0;
        pushIdle(4, 1'b1);
        checkOutput(-1);
        tick();
        TRIG_IN = 1'b1;
        pushBurst(0, 2, 1, 1, 1'b0);
        checkOutput(-1);
        TRIG_IN = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32: width of the delay, width and gap counters.
REQ-002 The block SHALL have parameter REP_W, default 16: width of the burst pulse-count field.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: number of flops in the TRIG_IN synchroniser; legal values are 2 or more.
REQ-004 The block SHALL have parameter ACTIVE_HIGH, default 1: GLITCH_OUT polarity; when 0, every GLITCH_OUT value in this document is inverted.
REQ-005 The block SHALL have port CLK  input  1  -- single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port RST_N  input  1  -- reset, asynchronous, active-low.
REQ-007 The block SHALL have port ARM  input  1  -- one-cycle pulse; latches configuration and arms the block.
REQ-008 The block SHALL have port ABORT  input  1  -- level; forces the block to IDLE.
REQ-009 The block SHALL have port TRIG_IN  input  1  -- asynchronous external trigger; its rising edge is used.
REQ-010 The block SHALL have port AUTO_REARM  input  1  -- sampled on ARM; 1 means return to ARMED after each burst.
REQ-011 The block SHALL have port CFG_DELAY  input  CNT_W  -- cycles from trigger detect to first pulse.
REQ-012 The block SHALL have port CFG_WIDTH  input  CNT_W  -- pulse high time, in cycles.
REQ-013 The block SHALL have port CFG_GAP  input  CNT_W  -- low time between pulses within a burst, in cycles.
REQ-014 The block SHALL have port CFG_COUNT  input  REP_W  -- number of pulses per burst.
REQ-015 The block SHALL have port GLITCH_OUT  output  1  -- registered glitch output.
REQ-016 The block SHALL have port STATE_ARMED  output  1  -- high while in state ARMED.
REQ-017 The block SHALL have port BUSY  output  1  -- high while in state DELAY, PULSE or GAP.
REQ-018 The block SHALL have port DONE  output  1  -- one-cycle pulse when a burst completes.

Function
REQ-019 The state machine SHALL have the states IDLE, ARMED, DELAY, PULSE and GAP.
REQ-020 On ARM in any state, the block SHALL latch all CFG_* inputs and AUTO_REARM into shadow registers and enter ARMED on the next cycle; CFG_* changes at other times SHALL have no effect.
REQ-021 TRIG_IN SHALL pass through SYNC_STAGES flops followed by an edge-detect flop; a rising edge is detected SYNC_STAGES+1 cycles after the synchronous rise, and only in ARMED; edges seen in other states are discarded.
REQ-022 On a detected edge in ARMED, the block SHALL enter DELAY if the latched delay is greater than 0, or enter PULSE directly if it is 0.
REQ-023 DELAY SHALL last exactly the latched delay (in cycles), then transition to PULSE.
REQ-024 In PULSE, GLITCH_OUT SHALL be 1 for exactly max(width,1) cycles and 0 in every other state (registered output, no combinational path).
REQ-025 After each pulse the block SHALL decrement the remaining count; if the remaining count is nonzero it SHALL enter GAP for max(gap,1) cycles and then PULSE, otherwise the burst is complete.
REQ-026 A latched count of 0 SHALL be treated as 1.
REQ-027 On burst completion, DONE SHALL pulse for one cycle coincident with the first cycle GLITCH_OUT is 0; the next state SHALL be ARMED if rearm is latched, else IDLE.
REQ-028 On re-entry to ARMED, the remaining count SHALL reload from the shadow register.
REQ-029 ABORT SHALL take priority over every other input including ARM: next state IDLE, GLITCH_OUT 0 next cycle, no DONE.
REQ-030 If ARM occurs during DELAY, PULSE or GAP, the burst SHALL be cancelled (GLITCH_OUT 0 next cycle, no DONE) and the block re-armed with the new configuration.
REQ-031 Counters SHALL be down-counters loaded with value-1 and SHALL never wrap; all-ones CFG values are legal and give 2^CNT_W-1 cycles.
REQ-032 Total pulse high time per burst SHALL equal max(count,1) x max(width,1) cycles, with zero jitter relative to the edge-detect cycle.

Reset
REQ-033 Asserting RST_N low SHALL asynchronously force state IDLE, GLITCH_OUT 0 (the inactive level per ACTIVE_HIGH), BUSY 0, STATE_ARMED 0, DONE 0, all counters and shadow registers 0, and the synchroniser flops 0.
REQ-034 Deassertion SHALL be synchronous to CLK, and a TRIG_IN that is already high at release SHALL NOT produce an edge.
REQ-035 Reset asserted mid-burst SHALL drop GLITCH_OUT without waiting for a clock edge.

Verification
REQ-036 Scenario 1: ARM with delay=10, width=95, gap=0, count=1, then a TRIG_IN rise -> GLITCH_OUT high 95 cycles starting 10 cycles after edge detect, then DONE pulse, then IDLE.
REQ-037 Scenario 2: delay=0, width=3, gap=5, count=4 -> pattern of 3 high and 5 low, repeated 4 times; exactly 4 pulses and one DONE.
REQ-038 Scenario 3: width=0, count=0 -> a single 1-cycle pulse.
REQ-039 Scenario 4: AUTO_REARM=1 and three triggers spaced 200 cycles apart -> three identical bursts; a trigger arriving mid-burst is ignored.
REQ-040 Scenario 5: ABORT in the 2nd pulse, and separately RST_N low mid-PULSE -> GLITCH_OUT 0 (next cycle for ABORT, immediately for reset), no DONE, IDLE.
REQ-041 Scenario 6: ACTIVE_HIGH=0, rerun scenario 1 -> inverted waveform, and output 1 during reset.
